secret_pal_ctl: RTL

CPU-side sequencer for the U001 protection PAL (registered PAL16R6 model) in the Mr. Do core.
- Detects qualified Z80 writes to the TRAM window and issues a single-cycle load strobe, with captured data, at the trailing edge of each write. This mirrors the PAL clock on TRAM WE rising.
- Decodes reads of the SECRE address and gates PAL output onto the CPU read bus.
- Stretches reads with WAIT while the PAL register is settling after a load.

---
 rtl/mrdo_pkg.sv | 19 +
 rtl/secret_bus_decode.sv | 49 ++++
 rtl/secret_pal_ctl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mrdo_pkg.sv
// mrdo_pkg: shared constants and types for the Mr. Do protection PAL sequencer.
//   TRAM_BASE / TRAM_MASK : TRAM write window decode
//   SECRE_ADDR            : protection read address
//   pal_state_t           : sequencer FSM states
package mrdo_pkg;

    localparam logic [15:0] TRAM_BASE  = 16'h8800;
    localparam logic [15:0] TRAM_MASK  = 16'hF800;
    localparam logic [15:0] SECRE_ADDR = 16'h9803;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ACT   = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_RD_SERVE = 3'd4
    } pal_state_t;

endpackage

// File: rtl/secret_bus_decode.sv
// secret_bus_decode: Z80 bus qualifiers for the protection PAL sequencer.
// Inputs : clk, rst_n, cpu_ce, cpu_addr, cpu_mreq_n, cpu_wr_n, cpu_rd_n
// Outputs: wq_hit  - qualified TRAM write sampled this clock (cpu_ce=1)
//          rq_hit  - qualified SECRE read sampled this clock (cpu_ce=1)
//          rq_lvl  - read qualifier level; live on ce cycles, last sample otherwise
//          wq_fall - trailing edge of a qualified write (ce cycle, wq 1->0)
module secret_bus_decode #(
    parameter logic [15:0] TRAM_BASE  = 16'h8800,
    parameter logic [15:0] TRAM_MASK  = 16'hF800,
    parameter logic [15:0] SECRE_ADDR = 16'h9803
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_rd_n,
    output logic        wq_hit,
    output logic        rq_hit,
    output logic        rq_lvl,
    output logic        wq_fall
);

    logic wq_c;
    logic rq_c;
    logic wq_r;
    logic rq_r;

    assign wq_c = ~cpu_mreq_n & ~cpu_wr_n & ((cpu_addr & TRAM_MASK) == TRAM_BASE);
    assign rq_c = ~cpu_mreq_n & ~cpu_rd_n & (cpu_addr == SECRE_ADDR);

    // Last ce-sampled qualifier values; the bus is only meaningful on ce cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq_r <= 1'b0;
            rq_r <= 1'b0;
        end else if (cpu_ce) begin
            wq_r <= wq_c;
            rq_r <= rq_c;
        end
    end

    assign wq_hit  = cpu_ce & wq_c;
    assign rq_hit  = cpu_ce & rq_c;
    assign rq_lvl  = cpu_ce ? rq_c : rq_r;
    assign wq_fall = cpu_ce & wq_r & ~wq_c;

endmodule

// File: rtl/secret_pal_ctl.sv
// secret_pal_ctl: CPU-side sequencer for the U001 protection PAL.
// Turns each qualified TRAM write into a one-clock PAL load strobe at the
// trailing edge of the write, serves SECRE reads from the PAL output, and
// holds the CPU in WAIT while the PAL register settles after a load.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cpu_ce                     CPU clock enable
//   cpu_addr/dout/mreq_n/wr_n/rd_n  Z80 bus
//   cpu_wait_n                 Z80 WAIT (active-low)
//   sec_oe, sec_dout           SECRE read gating / read data (FF when idle)
//   pal_din, pal_ld, pal_q     PAL data, load strobe, registered output
//   load_cnt                   loads issued (wraps)
module secret_pal_ctl #(
    parameter logic [15:0] TRAM_BASE  = mrdo_pkg::TRAM_BASE,
    parameter logic [15:0] TRAM_MASK  = mrdo_pkg::TRAM_MASK,
    parameter logic [15:0] SECRE_ADDR = mrdo_pkg::SECRE_ADDR,
    parameter int          SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_rd_n,
    output logic        cpu_wait_n,
    output logic        sec_oe,
    output logic [7:0]  sec_dout,
    output logic [7:0]  pal_din,
    output logic        pal_ld,
    input  logic [7:0]  pal_q,
    output logic [7:0]  load_cnt
);

    import mrdo_pkg::*;

    pal_state_t state;
    pal_state_t state_n;
    logic [7:0] hold;
    logic [2:0] settle_cnt;
    logic       capture;
    logic       wq_hit;
    logic       rq_hit;
    logic       rq_lvl;
    logic       wq_fall;

    secret_bus_decode #(
        .TRAM_BASE  (TRAM_BASE),
        .TRAM_MASK  (TRAM_MASK),
        .SECRE_ADDR (SECRE_ADDR)
    ) u_decode (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_ce     (cpu_ce),
        .cpu_addr   (cpu_addr),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_rd_n   (cpu_rd_n),
        .wq_hit     (wq_hit),
        .rq_hit     (rq_hit),
        .rq_lvl     (rq_lvl),
        .wq_fall    (wq_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (wq_hit)      state_n = ST_WR_ACT;
                else if (rq_hit) state_n = ST_RD_SERVE;
            end
            ST_WR_ACT: begin
                if (wq_fall) state_n = ST_LOAD;
            end
            ST_LOAD: state_n = ST_SETTLE;
            ST_SETTLE: begin
                // A new write restarts the sequence; the settle remainder is dropped.
                if (wq_hit)                 state_n = ST_WR_ACT;
                else if (settle_cnt <= 3'd1) state_n = rq_lvl ? ST_RD_SERVE : ST_IDLE;
            end
            ST_RD_SERVE: begin
                // A write here cannot happen on a real Z80; end the read and let IDLE take it.
                if (cpu_ce && (!rq_hit || wq_hit)) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Every ce cycle of an active write refreshes the hold register (last value wins).
    assign capture = wq_hit && (state_n == ST_WR_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= 8'h00;
            pal_din    <= 8'h00;
            load_cnt   <= 8'h00;
            settle_cnt <= 3'd0;
        end else begin
            if (capture) hold <= cpu_dout;
            if (state == ST_WR_ACT && state_n == ST_LOAD) pal_din <= hold;
            if (state == ST_LOAD) load_cnt <= load_cnt + 8'd1;
            if (state == ST_LOAD)
                settle_cnt <= 3'(SETTLE_CYC);
            else if (state == ST_SETTLE)
                settle_cnt <= (state_n == ST_SETTLE) ? settle_cnt - 3'd1 : 3'd0;
        end
    end

    assign pal_ld     = (state == ST_LOAD);
    assign sec_oe     = (state == ST_RD_SERVE);
    assign sec_dout   = sec_oe ? pal_q : 8'hFF;
    assign cpu_wait_n = ~(rq_lvl & ((state == ST_LOAD) | (state == ST_SETTLE)));

endmodule
